// File: rtl/feed_bus_arbiter_pkg.sv
// Shared types and default widths for the feed-buffer memory port arbiter.
package feed_bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W        = 26;
  localparam int unsigned DEF_DATA_W        = 16;
  localparam int unsigned DEF_USB_MAX_DEFER = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } arb_state_e;

  // Same encoding as the buffer's occupier field.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CART = 2'd1,
    OWN_USB  = 2'd2
  } owner_e;

endpackage

// File: rtl/feed_bus_arbiter_if.sv
// Requester-side bus into the arbiter: request/command in, ack/read data out.
interface feed_bus_arbiter_if
  import feed_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/feed_bus_arb_sel.sv
// Winner select (cart priority with USB starvation guard) plus the defer counter.
module feed_bus_arb_sel
  import feed_bus_arbiter_pkg::*;
#(
  parameter int unsigned USB_MAX_DEFER = DEF_USB_MAX_DEFER
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cart_req,
  input  logic   usb_req,
  input  logic   grant_en,
  output owner_e winner_c
);

  localparam int unsigned CNT_W = $clog2(USB_MAX_DEFER + 1);
  localparam logic [CNT_W-1:0] DEFER_MAX = CNT_W'(USB_MAX_DEFER);

  logic [CNT_W-1:0] defer_q;
  logic [CNT_W-1:0] defer_d;

  always_comb begin
    winner_c = OWN_NONE;
    if (cart_req && usb_req && (defer_q == DEFER_MAX)) winner_c = OWN_USB;
    else if (cart_req)                                  winner_c = OWN_CART;
    else if (usb_req)                                   winner_c = OWN_USB;
  end

  // Count cart grants that jumped a pending USB request; any other grant clears.
  always_comb begin
    defer_d = defer_q;
    if (grant_en && (winner_c != OWN_NONE)) begin
      if ((winner_c == OWN_CART) && usb_req)
        defer_d = (defer_q == DEFER_MAX) ? defer_q : defer_q + CNT_W'(1);
      else
        defer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) defer_q <= '0;
    else     defer_q <= defer_d;
  end

endmodule

// File: rtl/feed_bus_arbiter.sv
// Shares the feed-buffer memory port between cart and USB; one-cycle buffer strobe per access.
module feed_bus_arbiter
  import feed_bus_arbiter_pkg::*;
#(
  parameter int unsigned USB_MAX_DEFER = DEF_USB_MAX_DEFER,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  feed_bus_arbiter_if.slave   cart,
  feed_bus_arbiter_if.slave   usb,
  output logic [ADDR_W-1:0]   buf_addr,
  output logic                buf_from_cart,
  output logic                buf_from_usb,
  input  logic [ADDR_W-1:0]   buf_mem_addr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic              buf_from_cart_q, buf_from_cart_d;
  logic              buf_from_usb_q, buf_from_usb_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              cart_ack_q, cart_ack_d;
  logic              usb_ack_q, usb_ack_d;
  logic              grant_en_c;
  owner_e            winner_c;

  feed_bus_arb_sel #(.USB_MAX_DEFER(USB_MAX_DEFER)) u_sel (
    .clk      (clk),
    .rst      (rst),
    .cart_req (cart.req),
    .usb_req  (usb.req),
    .grant_en (grant_en_c),
    .winner_c (winner_c)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    grant_en_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_en_c = 1'b1;
        if (winner_c == OWN_CART) begin
          owner_d = OWN_CART;
          we_d    = cart.we;
          addr_d  = cart.addr;
          wdata_d = cart.wdata;
          state_d = ST_GRANT;
        end else if (winner_c == OWN_USB) begin
          owner_d = OWN_USB;
          we_d    = usb.we;
          addr_d  = usb.addr;
          wdata_d = usb.wdata;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        mem_addr_d = buf_mem_addr;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d = ST_ACK;
          end else if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = ST_ACK;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    buf_addr_d      = (state_d == ST_GRANT) ? addr_d : '0;
    buf_from_cart_d = (state_d == ST_GRANT) && (owner_d == OWN_CART);
    buf_from_usb_d  = (state_d == ST_GRANT) && (owner_d == OWN_USB);
    mem_req_d       = (state_d == ST_ISSUE);
    mem_we_d        = (state_d == ST_ISSUE) && we_d;
    cart_ack_d      = (state_d == ST_ACK) && (owner_d == OWN_CART);
    usb_ack_d       = (state_d == ST_ACK) && (owner_d == OWN_USB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_NONE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      mem_addr_q      <= '0;
      rdata_q         <= '0;
      buf_addr_q      <= '0;
      buf_from_cart_q <= 1'b0;
      buf_from_usb_q  <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      cart_ack_q      <= 1'b0;
      usb_ack_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      mem_addr_q      <= mem_addr_d;
      rdata_q         <= rdata_d;
      buf_addr_q      <= buf_addr_d;
      buf_from_cart_q <= buf_from_cart_d;
      buf_from_usb_q  <= buf_from_usb_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      cart_ack_q      <= cart_ack_d;
      usb_ack_q       <= usb_ack_d;
    end
  end

  assign buf_addr      = buf_addr_q;
  assign buf_from_cart = buf_from_cart_q;
  assign buf_from_usb  = buf_from_usb_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = wdata_q;
  assign cart.ack      = cart_ack_q;
  assign cart.rdata    = rdata_q;
  assign usb.ack       = usb_ack_q;
  assign usb.rdata     = rdata_q;

endmodule

// File: tb/tb_feed_bus_arbiter.sv
// Directed bench for feed_bus_arbiter: latency, arbitration, starvation guard, reset, frame swap.
module tb_feed_bus_arbiter;
  import feed_bus_arbiter_pkg::*;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] buf_addr;
  logic          buf_from_cart, buf_from_usb;
  logic [AW-1:0] buf_mem_addr;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  feed_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cart_bus ();
  feed_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) usb_bus ();

  feed_bus_arbiter #(.USB_MAX_DEFER(8), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cart          (cart_bus),
    .usb           (usb_bus),
    .buf_addr      (buf_addr),
    .buf_from_cart (buf_from_cart),
    .buf_from_usb  (buf_from_usb),
    .buf_mem_addr  (buf_mem_addr),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Translator stand-in: fixed offset so the latched address is predictable.
  assign buf_mem_addr = buf_addr + 26'h100;

  // Triple-buffer model: cart frame index advances on each cart strobe at offset 0.
  int unsigned swap_cnt;
  logic [1:0]  cart_frame;
  always @(negedge clk) begin
    if (rst) begin
      swap_cnt   <= 0;
      cart_frame <= 2'd0;
    end else if (buf_from_cart && (buf_addr == '0)) begin
      swap_cnt   <= swap_cnt + 1;
      cart_frame <= (cart_frame == 2'd2) ? 2'd0 : cart_frame + 2'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return {buf_addr, buf_from_cart, buf_from_usb, mem_req, mem_we, mem_addr, mem_wdata,
            cart_bus.ack, cart_bus.rdata, usb_bus.ack, usb_bus.rdata};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cart_bus.req = 0; cart_bus.we = 0; cart_bus.addr = '0; cart_bus.wdata = '0;
    usb_bus.req = 0; usb_bus.we = 0; usb_bus.addr = '0; usb_bus.wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    checks++;
    if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    checks++;
    if (dut.u_sel.defer_q !== 4'd0) begin errors++; $display("FAIL reset_defer: got %0d expected 0", dut.u_sel.defer_q); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cart_write();
    cart_bus.req = 1; cart_bus.we = 1; cart_bus.addr = 26'h1000000; cart_bus.wdata = 16'hBEEF;
    mem_ready = 1;
    tick();
    checks++;
    if ({buf_from_cart, buf_from_usb, buf_addr} !== {1'b1, 1'b0, 26'h1000000}) begin
      errors++; $display("FAIL cw_grant: got %b %b %h expected 1 0 1000000", buf_from_cart, buf_from_usb, buf_addr);
    end
    tick();
    checks++;
    if ({buf_from_cart, mem_req, mem_we, mem_wdata, mem_addr, cart_bus.ack} !== {1'b0, 1'b1, 1'b1, 16'hBEEF, 26'h1000100, 1'b0}) begin
      errors++; $display("FAIL cw_issue: got bfc=%b req=%b we=%b wd=%h ma=%h ack=%b expected 0 1 1 beef 1000100 0",
                         buf_from_cart, mem_req, mem_we, mem_wdata, mem_addr, cart_bus.ack);
    end
    tick();
    checks++;
    if ({cart_bus.ack, usb_bus.ack, mem_req} !== 3'b100) begin
      errors++; $display("FAIL cw_ack_t3: got ack=%b uack=%b req=%b expected 1 0 0", cart_bus.ack, usb_bus.ack, mem_req);
    end
    cart_bus.req = 0; cart_bus.we = 0;
    tick();
    checks++;
    if ({cart_bus.ack, buf_from_cart} !== 2'b00) begin
      errors++; $display("FAIL cw_idle: got ack=%b bfc=%b expected 0 0", cart_bus.ack, buf_from_cart);
    end
  endtask

  task automatic test_usb_read();
    mem_ready = 0; mem_rvalid = 0;
    usb_bus.req = 1; usb_bus.we = 0; usb_bus.addr = 26'h1E00000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      mem_ready  = (k == 4);
      mem_rvalid = (k == 7);
      mem_rdata  = (k == 7) ? 16'h1234 : 16'h0000;
      if (k == 1) begin
        checks++;
        if ({buf_from_usb, buf_from_cart, buf_addr} !== {1'b1, 1'b0, 26'h1E00000}) begin
          errors++; $display("FAIL ur_grant: got %b %b %h expected 1 0 1e00000", buf_from_usb, buf_from_cart, buf_addr);
        end
      end
      if (k == 2) begin
        checks++;
        if ({mem_addr, mem_we} !== {26'h1E00100, 1'b0}) begin
          errors++; $display("FAIL ur_mem_addr: got %h we=%b expected 1e00100 0", mem_addr, mem_we);
        end
      end
      if (k <= 7) begin
        checks++;
        if ({mem_req, usb_bus.ack} !== {((k >= 2) && (k <= 4)), 1'b0}) begin
          errors++; $display("FAIL ur_req_k%0d: got req=%b ack=%b expected %b 0", k, mem_req, usb_bus.ack, ((k >= 2) && (k <= 4)));
        end
      end else begin
        checks++;
        if ({usb_bus.ack, usb_bus.rdata, cart_bus.ack} !== {1'b1, 16'h1234, 1'b0}) begin
          errors++; $display("FAIL ur_ack: got ack=%b rd=%h cack=%b expected 1 1234 0", usb_bus.ack, usb_bus.rdata, cart_bus.ack);
        end
      end
    end
    usb_bus.req = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    cart_bus.req = 1; cart_bus.we = 1; cart_bus.addr = 26'h10; cart_bus.wdata = 16'h1111;
    usb_bus.req  = 1; usb_bus.we  = 1; usb_bus.addr  = 26'h20; usb_bus.wdata  = 16'h2222;
    mem_ready = 1; mem_rvalid = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({cart_bus.ack, usb_bus.ack} !== {(k == 3), (k == 7)}) begin
        errors++; $display("FAIL sim_acks_k%0d: got cart=%b usb=%b expected %b %b", k, cart_bus.ack, usb_bus.ack, (k == 3), (k == 7));
      end
      if (k == 1) begin
        checks++;
        if ({buf_from_cart, buf_addr, dut.u_sel.defer_q} !== {1'b1, 26'h10, 4'd1}) begin
          errors++; $display("FAIL sim_cart_first: got bfc=%b ba=%h defer=%0d expected 1 10 1", buf_from_cart, buf_addr, dut.u_sel.defer_q);
        end
      end
      if (k == 5) begin
        checks++;
        if ({buf_from_usb, buf_addr, dut.u_sel.defer_q} !== {1'b1, 26'h20, 4'd0}) begin
          errors++; $display("FAIL sim_usb_next: got bfu=%b ba=%h defer=%0d expected 1 20 0", buf_from_usb, buf_addr, dut.u_sel.defer_q);
        end
      end
      if (k == 6) begin
        checks++;
        if ({mem_wdata, mem_addr} !== {16'h2222, 26'h120}) begin
          errors++; $display("FAIL sim_usb_issue: got wd=%h ma=%h expected 2222 120", mem_wdata, mem_addr);
        end
      end
      if (cart_bus.ack) cart_bus.req = 0;
      if (usb_bus.ack)  usb_bus.req  = 0;
    end
  endtask

  task automatic test_starvation();
    int cart_grants = 0;
    bit usb_seen = 0;
    cart_bus.req = 1; cart_bus.we = 1; cart_bus.addr = 26'h40; cart_bus.wdata = 16'hC000;
    usb_bus.req  = 1; usb_bus.we  = 1; usb_bus.addr  = 26'h80; usb_bus.wdata  = 16'hD000;
    mem_ready = 1;
    for (int k = 0; k < 80 && !usb_seen; k++) begin
      tick();
      if (cart_bus.ack) begin
        cart_grants++;
        cart_bus.addr = cart_bus.addr + 26'h4;
        if (cart_grants == 8) begin
          checks++;
          if (dut.u_sel.defer_q !== 4'd8) begin
            errors++; $display("FAIL starve_defer_sat: got %0d expected 8", dut.u_sel.defer_q);
          end
        end
      end
      if (usb_bus.ack) begin
        usb_seen = 1;
        cart_bus.req = 0; usb_bus.req = 0;
        checks++;
        if (cart_grants !== 8) begin
          errors++; $display("FAIL starve_count: got %0d cart grants expected 8", cart_grants);
        end
        checks++;
        if (dut.u_sel.defer_q !== 4'd0) begin
          errors++; $display("FAIL starve_defer_clr: got %0d expected 0", dut.u_sel.defer_q);
        end
      end
    end
    if (!usb_seen) begin
      checks++; errors++;
      $display("FAIL starve_timeout: usb_ack got 0 expected 1 within 80 cycles");
      cart_bus.req = 0; usb_bus.req = 0;
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    mem_ready = 0; mem_rvalid = 0;
    cart_bus.req = 1; cart_bus.we = 0; cart_bus.addr = 26'h300;
    tick();
    tick(); mem_ready = 1;
    tick(); mem_ready = 0;
    checks++;
    if (dut.state_q !== ST_RD_WAIT) begin errors++; $display("FAIL rmr_in_rd_wait: got %0d expected %0d", dut.state_q, ST_RD_WAIT); end
    rst = 1; cart_bus.req = 0;
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 16'hDEAD;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL rmr_outs_zero: got %h expected 0", all_outs()); end
    tick();
    mem_rvalid = 0;
    checks++;
    if ({all_outs(), dut.state_q} !== {128'd0, ST_IDLE}) begin
      errors++; $display("FAIL rmr_ignore_rvalid: got %h state=%0d expected 0 IDLE", all_outs(), dut.state_q);
    end
    cart_bus.req = 1; cart_bus.we = 0; cart_bus.addr = 26'h310;
    for (int k = 1; k <= 3; k++) begin
      tick();
      mem_ready  = (k == 2);
      mem_rvalid = (k == 2);
      mem_rdata  = (k == 2) ? 16'h5A5A : 16'h0000;
      checks++;
      if (cart_bus.ack !== (k == 3)) begin
        errors++; $display("FAIL rmr_next_ack_k%0d: got %b expected %b", k, cart_bus.ack, (k == 3));
      end
    end
    checks++;
    if (cart_bus.rdata !== 16'h5A5A) begin errors++; $display("FAIL rmr_next_rdata: got %h expected 5a5a", cart_bus.rdata); end
    cart_bus.req = 0;
    tick();
  endtask

  task automatic test_frame_swap();
    int unsigned base;
    logic [1:0] exp_frame;
    base = swap_cnt;
    exp_frame = cart_frame;
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cart_bus.req = 1; cart_bus.we = 1; cart_bus.addr = '0; cart_bus.wdata = DW'(i);
      tick(); tick(); tick();
      checks++;
      if (cart_bus.ack !== 1'b1) begin errors++; $display("FAIL fs_ack_%0d: got %b expected 1", i, cart_bus.ack); end
      cart_bus.req = 0;
      tick();
      exp_frame = (exp_frame == 2'd2) ? 2'd0 : exp_frame + 2'd1;
      checks++;
      if ({swap_cnt, cart_frame} !== {base + 32'(i) + 32'd1, exp_frame}) begin
        errors++; $display("FAIL fs_swap_%0d: got swaps=%0d frame=%0d expected %0d %0d", i, swap_cnt - base, cart_frame, i + 1, exp_frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cart_write();
    test_usb_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid_read();
    test_frame_swap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time got 100000 expected completion earlier");
    $fatal(1);
  end

endmodule

// File: doc/feed_bus_arbiter.md
Name: feed_bus_arbiter

Overview:
- Sequences and shares the single memory port behind the feed buffer between two requesters: the GBA cartridge bus (hard real-time) and the USB host bridge.
- Per transaction: selects a winner, drives the buffer's address and source flags for exactly one cycle so the triple-buffer frame swap fires at most once, latches the translated memory address, then runs the memory handshake and returns read data.
- Sits between the cart/USB front ends and the buffer address translator plus memory controller.

Parameters:
- USB_MAX_DEFER, 8: number of consecutive cart grants allowed while USB is pending before USB is forced the next grant.
- ADDR_W, 26: cart/USB bus address width.
- DATA_W, 16: data word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cart_req  in  1  cart request; held until ack
- cart_we  in  1  1 = write
- cart_addr  in  ADDR_W  cart bus address
- cart_wdata  in  DATA_W  write data
- cart_ack  out  1  one-cycle completion pulse
- cart_rdata  out  DATA_W  read data; valid with cart_ack
- usb_req, usb_we, usb_addr, usb_wdata, usb_ack, usb_rdata: same as the cart_* ports, USB side
- buf_addr  out  ADDR_W  address to the buffer translator
- buf_from_cart  out  1  source flag to the buffer
- buf_from_usb  out  1  source flag to the buffer
- buf_mem_addr  in  ADDR_W  translated address from the buffer (combinational)
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  latched translated address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0; FSM = IDLE; defer_cnt = 0; owner = NONE.
- FSM states: IDLE, GRANT, ISSUE, RD_WAIT, ACK.
- IDLE, arbitration:
  - If both requesters are pending and defer_cnt == USB_MAX_DEFER, grant USB.
  - Otherwise cart wins whenever cart_req = 1; else USB wins if usb_req = 1.
  - On a grant, latch owner, we, addr and wdata from the winner; go to GRANT.
- defer_cnt update, on each grant:
  - Cart grant with usb_req = 1: increment, saturating at USB_MAX_DEFER.
  - USB grant: clear to 0.
  - Any grant with usb_req = 0: clear to 0.
- GRANT, exactly 1 cycle:
  - buf_addr = latched addr.
  - buf_from_cart or buf_from_usb = 1, matching owner.
  - Capture buf_mem_addr into mem_addr; go to ISSUE.
  - In every other state buf_from_* = 0 and buf_addr = 0. This guarantees a single frame swap per offset-0 access.
- ISSUE:
  - mem_req = 1, with mem_we and mem_wdata from the latch.
  - Hold until mem_ready = 1.
  - On accept: write goes to ACK; read goes to RD_WAIT. If mem_rvalid is also 1 in the accept cycle, a read goes straight to ACK and latches mem_rdata.
- RD_WAIT: mem_req = 0; wait for mem_rvalid; latch mem_rdata; go to ACK.
- ACK, 1 cycle:
  - Pulse owner's *_ack; *_rdata = latched data (holds until the next read completes).
  - Go to IDLE; owner = NONE.
- Requester rule: deassert req in the cycle after ack, as a registered response. IDLE therefore never re-grants a completed request.
- Latency, request sampled in IDLE at cycle t:
  - Write with immediate mem_ready: ack at t+3.
  - Read with mem_ready at t+2 and rvalid at t+4: ack at t+5.
- Non-preemptive: a request arriving mid-transaction waits for IDLE.
- Simultaneous cart_req and usb_req in IDLE: cart wins unless the defer limit has been reached.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; no ack; mem_req drops.
  - In-flight mem_rvalid is ignored.
- Inputs from the requester are ignored after the latch in IDLE; changes mid-transaction have no effect.

Decomposition:
- Shared package (gba_io_fpga_header): arbiter state enum; owner enum (NONE/CART/USB), reusing the buffer's occupier encoding; ADDR_W/DATA_W defaults.
- One natural sub-module, feed_bus_arb_sel: combinational winner select plus the defer counter. The FSM and datapath latches stay in the top module.

Test Plan:
- Single cart write:
  - Stimulus: addr 0x1000000, wdata 0xBEEF, mem_ready tied 1.
  - Response: buf_from_cart high exactly 1 cycle; mem_addr = buf_mem_addr; mem_we = 1 with mem_wdata 0xBEEF; cart_ack at t+3.
- USB read with slow memory:
  - Stimulus: addr 0x1E00000; mem_ready at t+4; rvalid 3 cycles later with 0x1234.
  - Response: usb_ack and usb_rdata = 0x1234 in the cycle after rvalid; mem_req high only in ISSUE.
- Simultaneous requests:
  - Stimulus: cart_req and usb_req both high in the same IDLE cycle.
  - Response: cart served first; USB granted on the next IDLE; no ack overlap.
- Starvation guard:
  - Stimulus: cart requests back-to-back, usb_req held, USB_MAX_DEFER = 8.
  - Response: USB granted after exactly 8 cart grants; defer_cnt then 0.
- Reset mid-read:
  - Stimulus: rst in RD_WAIT, then mem_rvalid arrives.
  - Response: no ack; all outputs 0; the next request completes normally.
- Frame-swap integrity:
  - Stimulus: three cart accesses at video offset 0, using the real buffer model.
  - Response: the cart frame index advances exactly once per access.
